// File: rtl/prbs_checker.sv
// Self-synchronising receive checker for the x^49 + x^40 + 1 PRBS bitstream: hunt, verify, lock, then flywheel.
// Optional BIT_COUNT output when PRBS_CHECKER_BITCNT_EN is defined.
module prbs_checker #(
    parameter int LOCK_BITS   = 64,
    parameter int LOSS_WINDOW = 1024,
    parameter int LOSS_ERRS   = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 DATA_IN,
    input  logic                 DATA_VALID,
    input  logic                 CLR_CNT,
    output logic                 LOCKED,
    output logic                 ERROR,
    output logic [CNT_WIDTH-1:0] ERR_COUNT
`ifdef PRBS_CHECKER_BITCNT_EN
    ,
    output logic [47:0]          BIT_COUNT
`endif
);

    localparam int GW = (LOCK_BITS > 1) ? $clog2(LOCK_BITS) : 1;
    localparam int WW = $clog2(LOSS_WINDOW + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);

    localparam logic [5:0]    FILL_LAST  = 6'd48;
    localparam logic [GW-1:0] GOOD_LAST  = GW'(LOCK_BITS - 1);
    localparam logic [WW-1:0] WIN_LIMIT  = WW'(LOSS_WINDOW);
    localparam logic [EW-1:0] ERRS_LIMIT = EW'(LOSS_ERRS);

    typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCK} state_t;

    state_t               state_reg;
    logic [48:0]          s_reg;
    logic [5:0]           fill_reg;
    logic [GW-1:0]        good_reg;
    logic [WW-1:0]        win_cnt_reg;
    logic [EW-1:0]        win_err_reg;
    logic                 locked_reg;
    logic                 error_reg;
    logic [CNT_WIDTH-1:0] err_count_reg;

    logic                 pred;
    logic                 mismatch;
    logic [48:0]          s_shift;
    logic [WW-1:0]        win_cnt_next;
    logic [EW-1:0]        win_err_next;
    logic                 lock_err;

    assign pred         = s_reg[48] ^ s_reg[39];
    assign mismatch     = DATA_IN ^ pred;
    assign s_shift      = {s_reg[47:0], DATA_IN};
    assign win_cnt_next = win_cnt_reg + 1'b1;
    assign win_err_next = win_err_reg + EW'(mismatch);
    assign lock_err     = DATA_VALID && (state_reg == ST_LOCK) && mismatch;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg     <= ST_HUNT;
            s_reg         <= '0;
            fill_reg      <= '0;
            good_reg      <= '0;
            win_cnt_reg   <= '0;
            win_err_reg   <= '0;
            locked_reg    <= 1'b0;
            error_reg     <= 1'b0;
            err_count_reg <= '0;
        end else begin
            error_reg <= 1'b0;

            // Clear wins over a coincident error; otherwise saturate at all-ones.
            if (CLR_CNT)
                err_count_reg <= '0;
            else if (lock_err && !(&err_count_reg))
                err_count_reg <= err_count_reg + 1'b1;

            if (DATA_VALID) begin
                case (state_reg)
                    ST_HUNT: begin
                        s_reg <= s_shift;
                        if (fill_reg == FILL_LAST) begin
                            state_reg <= ST_VERIFY;
                            fill_reg  <= '0;
                            good_reg  <= '0;
                        end else begin
                            fill_reg <= fill_reg + 1'b1;
                        end
                    end
                    ST_VERIFY: begin
                        s_reg <= s_shift;
                        if (mismatch) begin
                            state_reg <= ST_HUNT;
                            fill_reg  <= '0;
                        end else if (good_reg == GOOD_LAST) begin
                            // An all-zero register is a fixed point of the LFSR, never a valid lock.
                            if (s_shift == '0) begin
                                state_reg <= ST_HUNT;
                                fill_reg  <= '0;
                            end else begin
                                state_reg   <= ST_LOCK;
                                locked_reg  <= 1'b1;
                                win_cnt_reg <= '0;
                                win_err_reg <= '0;
                            end
                        end else begin
                            good_reg <= good_reg + 1'b1;
                        end
                    end
                    ST_LOCK: begin
                        s_reg     <= {s_reg[47:0], pred};
                        error_reg <= mismatch;
                        if (win_err_next == ERRS_LIMIT) begin
                            state_reg   <= ST_HUNT;
                            fill_reg    <= '0;
                            locked_reg  <= 1'b0;
                            win_cnt_reg <= '0;
                            win_err_reg <= '0;
                        end else if (win_cnt_next == WIN_LIMIT) begin
                            win_cnt_reg <= '0;
                            win_err_reg <= '0;
                        end else begin
                            win_cnt_reg <= win_cnt_next;
                            win_err_reg <= win_err_next;
                        end
                    end
                    default: begin
                        state_reg <= ST_HUNT;
                        fill_reg  <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PRBS_CHECKER_BITCNT_EN
    logic [47:0] bit_count_reg;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            bit_count_reg <= '0;
        else if (CLR_CNT)
            bit_count_reg <= '0;
        else if (DATA_VALID && (state_reg == ST_LOCK) && !(&bit_count_reg))
            bit_count_reg <= bit_count_reg + 1'b1;
    end

    assign BIT_COUNT = bit_count_reg;
`endif

    assign LOCKED    = locked_reg;
    assign ERROR     = error_reg;
    assign ERR_COUNT = err_count_reg;

endmodule
